// File: rtl/scan_pkg.sv
// Shared constants and state encoding for the multiplexed digit scanner.
package scan_pkg;

  localparam int unsigned DIV_DEF   = 4;
  localparam int unsigned BLANK_DEF = 2;
  localparam int unsigned N_DIGITS  = 4;
  localparam int unsigned IDX_W     = 2;
  localparam int unsigned NIB_W     = 4;
  localparam int unsigned CNT_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BLNK = 2'd1,
    ST_SHOW = 2'd2
  } state_e;

endpackage

// File: rtl/digit_scan_ctrl_if.sv
// Control inputs and decoder-side outputs of the digit scanner.
interface digit_scan_ctrl_if;
  import scan_pkg::*;

  logic                RUN;
  logic [N_DIGITS-1:0] MASK;
  logic [NIB_W-1:0]    D0;
  logic [NIB_W-1:0]    D1;
  logic [NIB_W-1:0]    D2;
  logic [NIB_W-1:0]    D3;
  logic                A0;
  logic                A1;
  logic                EN;
  logic [NIB_W-1:0]    DIG_DATA;
  logic                FRAME;

  modport master (
    output RUN, MASK, D0, D1, D2, D3,
    input  A0, A1, EN, DIG_DATA, FRAME
  );

  modport slave (
    input  RUN, MASK, D0, D1, D2, D3,
    output A0, A1, EN, DIG_DATA, FRAME
  );
endinterface

// File: rtl/scan_next_sel.sv
// Picks the next enabled digit scanning upward from cur+1 with wrap 3->0.
// A lone enabled current digit reselects itself and counts as a wrap.
module scan_next_sel
  import scan_pkg::*;
(
  input  logic [IDX_W-1:0]    cur_i,
  input  logic [N_DIGITS-1:0] mask_i,
  output logic [IDX_W-1:0]    nxt_c_o,
  output logic                wrap_c_o,
  output logic                none_c_o
);

  logic [IDX_W-1:0] cand;

  // Walk candidates farthest-first so the nearest enabled one wins.
  always_comb begin
    nxt_c_o = cur_i;
    cand    = '0;
    for (int k = N_DIGITS; k >= 1; k--) begin
      cand = cur_i + IDX_W'(k);
      if (mask_i[cand]) nxt_c_o = cand;
    end
    none_c_o = ~|mask_i;
    wrap_c_o = !none_c_o && (nxt_c_o <= cur_i);
  end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed 4-digit display scanner with registered decoder outputs.
// Optional feature macro SCAN_BLANK_EN: adds a dark BLNK gap before each digit.
module digit_scan_ctrl
  import scan_pkg::*;
#(
  parameter int unsigned DIV   = DIV_DEF,
  parameter int unsigned BLANK = BLANK_DEF
) (
  input logic               CLK,
  input logic               RST,
  digit_scan_ctrl_if.slave  bus
);

  if (DIV < 2 || DIV > 65535) begin : g_bad_div
    $error("digit_scan_ctrl: DIV out of range 2..65535");
  end
  if (BLANK < 1 || BLANK > 255) begin : g_bad_blank
    $error("digit_scan_ctrl: BLANK out of range 1..255");
  end

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
`ifdef SCAN_BLANK_EN
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);
  localparam state_e           ST_FIRST   = ST_BLNK;
`else
  localparam state_e           ST_FIRST   = ST_SHOW;
`endif

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              en_q, en_d;
  logic              frame_q, frame_d;
  logic [NIB_W-1:0]  dig_q, dig_d;

  logic [IDX_W-1:0]  sel_cur;
  logic [IDX_W-1:0]  sel_nxt;
  logic              sel_wrap;
  logic              sel_none;
  logic [NIB_W-1:0]  d_arr [N_DIGITS];

  // Digit nibbles as an indexable array.
  always_comb begin
    d_arr[0] = bus.D0;
    d_arr[1] = bus.D1;
    d_arr[2] = bus.D2;
    d_arr[3] = bus.D3;
  end

  // From IDLE, searching upward from digit 3 yields the lowest set bit.
  assign sel_cur = (state_q == ST_IDLE) ? IDX_W'(N_DIGITS - 1) : idx_q;

  scan_next_sel u_next_sel (
    .cur_i    (sel_cur),
    .mask_i   (bus.MASK),
    .nxt_c_o  (sel_nxt),
    .wrap_c_o (sel_wrap),
    .none_c_o (sel_none)
  );

  // Next-state, slot counter and next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    frame_d = 1'b0;
    en_d    = 1'b1;
    dig_d   = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.RUN && !sel_none) begin
          state_d = ST_FIRST;
          idx_d   = sel_nxt;
          cnt_d   = '0;
        end
      end
`ifdef SCAN_BLANK_EN
      ST_BLNK: begin
        if (cnt_q == BLANK_LAST) begin
          cnt_d   = '0;
          state_d = sel_none ? ST_IDLE : ST_SHOW;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      ST_SHOW: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (sel_none) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_FIRST;
            idx_d   = sel_nxt;
            frame_d = sel_wrap;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Dropping RUN parks the scanner but keeps the last address.
    if (!bus.RUN) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      idx_d   = idx_q;
      frame_d = 1'b0;
    end

    en_d  = !((state_d == ST_SHOW) && bus.MASK[idx_d]);
    dig_d = (state_d == ST_IDLE) ? '0 : d_arr[idx_d];
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      en_q    <= 1'b1;
      frame_q <= 1'b0;
      dig_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      frame_q <= frame_d;
      dig_q   <= dig_d;
    end
  end

  assign bus.A0       = idx_q[1];
  assign bus.A1       = idx_q[0];
  assign bus.EN       = en_q;
  assign bus.DIG_DATA = dig_q;
  assign bus.FRAME    = frame_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Self-checking bench for digit_scan_ctrl using a slot-position reference model.
module tb_digit_scan_ctrl;

  localparam int DIV_T = 4;
`ifdef SCAN_BLANK_EN
  localparam int BLANK_T = 2;
`else
  localparam int BLANK_T = 0;
`endif
  localparam int SLOT = DIV_T + BLANK_T;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  digit_scan_ctrl_if bus ();

  digit_scan_ctrl #(.DIV(DIV_T), .BLANK(2)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: active flag, lit digit and position inside its slot.
  bit         m_active = 1'b0;
  int         m_idx    = 0;
  int         m_pos    = 0;
  bit         m_frame  = 1'b0;
  bit         m_en     = 1'b1;
  logic [3:0] m_dig    = 4'h0;

  function automatic int next_digit(int cur, logic [3:0] mask);
    for (int k = 1; k <= 4; k++) begin
      if (mask[(cur + k) % 4]) return (cur + k) % 4;
    end
    return cur;
  endfunction

  function automatic logic [7:0] obs_vec();
    return {bus.A0, bus.A1, bus.EN, bus.DIG_DATA, bus.FRAME};
  endfunction

  function automatic logic [7:0] exp_vec();
    logic [1:0] a;
    a = 2'(m_idx);
    return {a, m_en, m_dig, m_frame};
  endfunction

  // One clock edge: advance the model with the inputs seen at the edge.
  task automatic tick();
    logic [3:0] d [4];
    logic [3:0] mask;
    int nxt;
    @(posedge clk);
    cyc++;
    d[0] = bus.D0; d[1] = bus.D1; d[2] = bus.D2; d[3] = bus.D3;
    mask = bus.MASK;
    m_frame = 1'b0;
    if (rst) begin
      m_active = 1'b0; m_idx = 0; m_pos = 0;
    end else if (!bus.RUN) begin
      m_active = 1'b0; m_pos = 0;
    end else if (!m_active) begin
      if (mask != 4'h0) begin
        m_active = 1'b1; m_idx = next_digit(3, mask); m_pos = 0;
      end
    end else begin
      m_pos++;
      if (BLANK_T > 0 && m_pos == BLANK_T && mask == 4'h0) begin
        m_active = 1'b0; m_pos = 0;
      end else if (m_pos == SLOT) begin
        m_pos = 0;
        if (mask == 4'h0) begin
          m_active = 1'b0;
        end else begin
          nxt = next_digit(m_idx, mask);
          m_frame = (nxt <= m_idx);
          m_idx = nxt;
        end
      end
    end
    m_en  = !(m_active && m_pos >= BLANK_T && mask[m_idx]);
    m_dig = m_active ? d[m_idx] : 4'h0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.RUN = 1'b1; bus.MASK = 4'hF;
    tick();
    checks++;
    if (obs_vec() !== 8'b0010_0000) begin
      errors++;
      $display("FAIL reset_state got=%b want=%b", obs_vec(), 8'b0010_0000);
    end
    rst = 1'b0; bus.RUN = 1'b0;
    tick();
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset_idle got=%b want=%b", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_pattern(input logic [3:0] mask, input int period, input string name);
    int f0 = -1;
    int f1 = -1;
    int lows = 0;
    int want_lows;
    want_lows = ($countones(mask)) * DIV_T;
    bus.RUN = 1'b0;
    tick();
    bus.MASK = mask; bus.RUN = 1'b1;
    for (int i = 0; i < 20 * SLOT && f1 < 0; i++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, obs_vec(), exp_vec());
      end
      if (bus.FRAME === 1'b1) begin
        if (f0 < 0) f0 = cyc; else f1 = cyc;
      end
      if (f0 >= 0 && f1 < 0 && bus.EN === 1'b0) lows++;
    end
    checks++;
    if (f1 < 0) begin
      errors++;
      $display("FAIL %s_frame_period got=no_two_frames want=%0d", name, period);
    end else if (f1 - f0 != period) begin
      errors++;
      $display("FAIL %s_frame_period got=%0d want=%0d", name, f1 - f0, period);
    end
    checks++;
    if (lows != want_lows) begin
      errors++;
      $display("FAIL %s_lit_cycles got=%0d want=%0d", name, lows, want_lows);
    end
  endtask

  task automatic test_run_drop();
    bit found = 1'b0;
    logic exp_en;
    bus.RUN = 1'b0;
    tick();
    bus.MASK = 4'hF; bus.RUN = 1'b1;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL run_drop_pre cyc=%0d got=%b want=%b", cyc, obs_vec(), exp_vec());
      end
      if (m_active && m_idx == 2 && m_pos == BLANK_T + 1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL run_drop_reach got=timeout want=digit2_show");
    end
    bus.RUN = 1'b0;
    tick();
    checks++;
    if (obs_vec() !== 8'b1010_0000) begin
      errors++;
      $display("FAIL run_drop_idle got=%b want=%b", obs_vec(), 8'b1010_0000);
    end
    bus.MASK = 4'b0110; bus.RUN = 1'b1;
    tick();
    exp_en = (BLANK_T > 0);
    checks++;
    if ({bus.A0, bus.A1, bus.EN} !== {2'b01, exp_en}) begin
      errors++;
      $display("FAIL run_restart got=%b want=%b", {bus.A0, bus.A1, bus.EN}, {2'b01, exp_en});
    end
    for (int i = 0; i < 2 * SLOT; i++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL run_restart_scan cyc=%0d got=%b want=%b", cyc, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_mask_clear();
    bit found = 1'b0;
    bus.RUN = 1'b0;
    tick();
    bus.MASK = 4'hF; bus.RUN = 1'b1;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (m_active && m_pos == BLANK_T + 1) found = 1'b1;
    end
    bus.MASK[m_idx] = 1'b0;
    tick();
    checks++;
    if (bus.EN !== 1'b1 || !found) begin
      errors++;
      $display("FAIL mask_clear_dark got=%b want=1", bus.EN);
    end
    for (int i = 0; i < 3 * SLOT; i++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL mask_clear_timing cyc=%0d got=%b want=%b", cyc, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid_slot();
    bus.RUN = 1'b0;
    tick();
    bus.MASK = 4'hF; bus.RUN = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (obs_vec() !== 8'b0010_0000) begin
      errors++;
      $display("FAIL reset_mid_slot got=%b want=%b", obs_vec(), 8'b0010_0000);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset_release got=%b want=%b", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    bus.RUN = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(59) == 0) bus.RUN = ~bus.RUN;
      if ($urandom_range(24) == 0) bus.MASK = 4'($urandom);
      if ($urandom_range(3) == 0) begin
        bus.D0 = 4'($urandom); bus.D1 = 4'($urandom);
        bus.D2 = 4'($urandom); bus.D3 = 4'($urandom);
      end
      rst = ($urandom_range(299) == 0);
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc=%0d got=%b want=%b", cyc, obs_vec(), exp_vec());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    bus.RUN  = 1'b0;
    bus.MASK = 4'h0;
    bus.D0 = 4'($urandom); bus.D1 = 4'($urandom);
    bus.D2 = 4'($urandom); bus.D3 = 4'($urandom);
    test_reset();
    test_pattern(4'b1111, 4 * SLOT, "scan_1111");
    test_pattern(4'b0101, 2 * SLOT, "scan_0101");
    test_pattern(4'b1000, SLOT, "scan_1000");
    test_run_drop();
    test_mask_clear();
    test_reset_mid_slot();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/digit_scan_ctrl.md
DIGIT_SCAN_CTRL -- requirements
Module: digit_scan_ctrl

Interface
REQ-001 Parameter DIV, default 4: clock cycles each digit is lit (SHOW phase), legal range 2..65535.
REQ-002 Parameter BLANK, default 2: clock cycles of all-dark gap before each digit, legal range 1..255.
REQ-003 The block SHALL have exactly one clock; reset is synchronous and active-high.
REQ-004 CLK  input  1  rising-edge clock.
REQ-005 RST  input  1  synchronous active-high reset.
REQ-006 RUN  input  1  scan enable; low forces the display dark.
REQ-007 MASK  input  4  per-digit enable; bit i set = digit i is scanned.
REQ-008 D0..D3  input  4 each  nibble shown on digits 0..3.
REQ-009 A0  output  1  decoder select MSB; digit index = {A0,A1}.
REQ-010 A1  output  1  decoder select LSB.
REQ-011 EN  output  1  decoder disable, active-high (1 = all digit lines off).
REQ-012 DIG_DATA  output  4  nibble for the currently addressed digit.
REQ-013 FRAME  output  1  one-cycle pulse at each scan wrap.

Function
REQ-014 All outputs SHALL be registered; FSM states IDLE, BLNK, SHOW.
REQ-015 IDLE: EN=1; if RUN=1 and MASK!=0, next state BLNK with {A0,A1} = lowest set MASK bit.
REQ-016 BLNK: EN=1, address and DIG_DATA already updated to the target digit; after BLANK cycles go SHOW.
REQ-017 SHOW: EN=0 while MASK[current]=1; lasts exactly DIV cycles, then next digit selected and state BLNK.
REQ-018 Next digit = first set MASK bit scanning upward from current+1 with wrap 3->0; if only current is set, the same digit is reselected.
REQ-019 FRAME SHALL pulse for one cycle, coincident with the BLNK entry, when the new index <= old index (wrap, including single-digit reselection).
REQ-020 DIG_DATA SHALL equal D[index] sampled every cycle in BLNK and SHOW; 0 in IDLE.
REQ-021 MASK bit of the lit digit cleared mid-SHOW: EN=1 from the next cycle, slot timing unchanged.
REQ-022 MASK=0 at end of SHOW or BLNK: next state IDLE, EN=1, address held.
REQ-023 RUN deasserted in any state: next cycle IDLE, EN=1, counters cleared, address held.
REQ-024 MASK changes take effect only at digit selection points (REQ-015, REQ-018), except REQ-021/022.

Reset
REQ-025 RST=1 SHALL, at the next edge, force state IDLE, A0=0, A1=0, EN=1, DIG_DATA=0, FRAME=0, counters 0, overriding RUN.
REQ-026 Reset mid-SHOW SHALL darken the display within one cycle; no partial slot resumes.

Configuration
REQ-027 Macro SCAN_BLANK_EN defined: BLNK phase present as in REQ-016.
REQ-028 SCAN_BLANK_EN undefined: BLNK state and BLANK counter SHALL not be built; transitions go directly to SHOW, address changing on the SHOW-to-SHOW boundary, BLANK parameter ignored.

Structure
REQ-029 Package scan_pkg SHALL hold the state encoding, DIV/BLANK defaults, and digit count constant (4).
REQ-030 Sub-module scan_next_sel SHALL implement REQ-018 combinationally (inputs current index, MASK; outputs next index, wrap flag, none flag).

Verification
REQ-031 DIV=4, BLANK=2, MASK=1111, RUN=1 after reset -> address 0,1,2,3,0 repeating, EN pattern 1,1,0,0,0,0 per digit, FRAME once per 24 cycles.
REQ-032 MASK=0101 -> only digits 0 and 2 lit, FRAME at each 2->0 transition, period 12 cycles.
REQ-033 MASK=1000 -> digit 3 reselected each slot, FRAME every 6 cycles, DIG_DATA=D3.
REQ-034 RUN dropped mid-SHOW of digit 2 -> EN=1 next cycle, state IDLE, A0=1 A1=0 held; RUN re-raised -> restart at lowest set MASK bit.
REQ-035 RST asserted during BLNK with RUN=1 -> next cycle all outputs at REQ-025 values.
REQ-036 Build without SCAN_BLANK_EN, MASK=1111 -> EN stays 0 continuously, address advances every 4 cycles.
